alu_result_stage: RTL

- Registered stage directly downstream of the combinational ALU.
- Takes the ALU's raw result and Z/C/V/S flags and applies the S1C88 decimal (SC.D) and unpack (SC.U) corrections to byte add/subtract ops.
- Merges flags into the SC register under a decoder-supplied mask and presents the final result to register writeback over a valid/ready handshake.
- Owns the architectural SC register; the ALU carry input is taken from sc[1].

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu_result_stage_if.sv | 33 +++
 rtl/bcd_adjust.sv | 69 ++++++
 rtl/alu_result_stage.sv | 65 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, flag/SC bit positions and the
// registered-result record used by the result stage.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_ADC  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SBC  = 5'd3,
    ALU_CMP  = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_INC  = 5'd8,
    ALU_DEC  = 5'd9,
    ALU_NEG  = 5'd10,
    ALU_CPL  = 5'd11,
    ALU_SLA  = 5'd12,
    ALU_SRA  = 5'd13,
    ALU_SLL  = 5'd14,
    ALU_SRL  = 5'd15,
    ALU_RL   = 5'd16,
    ALU_RR   = 5'd17,
    ALU_RLC  = 5'd18,
    ALU_RRC  = 5'd19,
    ALU_PASS = 5'd20
  } alu_op_e;

  typedef enum logic [1:0] {
    OPC_NONE = 2'd0,
    OPC_ADD  = 2'd1,
    OPC_SUB  = 2'd2
  } op_class_e;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_S = 3;

  localparam int SC_Z  = 0;
  localparam int SC_C  = 1;
  localparam int SC_V  = 2;
  localparam int SC_S  = 3;
  localparam int SC_D  = 4;
  localparam int SC_U  = 5;
  localparam int SC_I0 = 6;
  localparam int SC_I1 = 7;

  localparam logic [7:0] SC_RESET_VAL = 8'hC0;

  typedef struct packed {
    logic [15:0] result;
    logic        size;
    logic        wb_en;
  } alu_rsp_t;

  // Only byte add/subtract-class ops are candidates for decimal/unpack fixup.
  function automatic op_class_e op_class(alu_op_e op, logic size);
    op_class_e c;
    c = OPC_NONE;
    if (!size) begin
      case (op)
        ALU_ADD, ALU_ADC:          c = OPC_ADD;
        ALU_SUB, ALU_SBC, ALU_CMP: c = OPC_SUB;
        default:                   c = OPC_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-result-stage and result-stage-to-writeback handshake bundle.
interface alu_result_stage_if;
  import alu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  alu_op_e     alu_op;
  logic        size;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] r_in;
  logic [3:0]  flags_in;
  logic [3:0]  flag_mask;
  logic        wb_en_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_size;
  logic        out_wb_en;

  modport master (
    output in_valid, alu_op, size, a_in, b_in, r_in, flags_in, flag_mask,
           wb_en_in, out_ready,
    input  in_ready, out_valid, out_result, out_size, out_wb_en
  );

  modport slave (
    input  in_valid, alu_op, size, a_in, b_in, r_in, flags_in, flag_mask,
           wb_en_in, out_ready,
    output in_ready, out_valid, out_result, out_size, out_wb_en
  );

endinterface

// File: rtl/bcd_adjust.sv
// Combinational S1C88 decimal (D) / unpack (U) fixup of a byte add/sub result.
module bcd_adjust
  import alu_pkg::*;
(
  input  op_class_e  opc,
  input  logic       d,
  input  logic       u,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] r,
  input  logic [3:0] flags_in,
  output logic [7:0] r_out,
  output logic [3:0] flags_out
);

  logic       h;
  logic       c_in;
  logic       lo_gt9;
  logic [3:0] nib;
  logic [7:0] adj;
  logic [7:0] res;
  logic       c;

  always_comb begin
    h         = a[4] ^ b[4] ^ r[4];
    c_in      = flags_in[FLG_C];
    lo_gt9    = (r[3:0] > 4'd9);
    nib       = r[3:0];
    adj       = r;
    res       = r;
    c         = c_in;
    r_out     = r;
    flags_out = flags_in;
    if (opc != OPC_NONE && (d || u)) begin
      if (u) begin
        // Unpack: only the low digit survives; carry is the nibble carry/borrow.
        c = h;
        if (d) begin
          if (opc == OPC_ADD) begin
            c = h || lo_gt9;
            if (c) nib = r[3:0] + 4'd6;
          end else if (h) begin
            nib = r[3:0] - 4'd6;
          end
        end
        res = {4'h0, nib};
      end else if (opc == OPC_ADD) begin
        adj = (h || lo_gt9) ? r + 8'h06 : r;
        if (c_in || adj > 8'h99) begin
          res = adj + 8'h60;
          c   = 1'b1;
        end else begin
          res = adj;
          c   = 1'b0;
        end
      end else begin
        adj = h ? r - 8'h06 : r;
        res = c_in ? adj - 8'h60 : adj;
        c   = c_in;
      end
      r_out            = res;
      flags_out[FLG_Z] = (res == 8'h00);
      flags_out[FLG_C] = c;
      flags_out[FLG_V] = 1'b0;
      flags_out[FLG_S] = res[7];
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: BCD/unpack correction, SC flag merge and a
// one-deep valid/ready output register toward writeback.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter logic [7:0] SC_RESET = SC_RESET_VAL
) (
  input  logic               clk,
  input  logic               reset,
  alu_result_stage_if.slave  bus,
  input  logic               sc_we,
  input  logic [7:0]         sc_wdata,
  output logic [7:0]         sc
);

  logic       accept;
  op_class_e  opc;
  logic [7:0] adj_byte;
  logic [3:0] adj_flags;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign opc          = op_class(bus.alu_op, bus.size);

  bcd_adjust u_bcd (
    .opc       (opc),
    .d         (sc[SC_D]),
    .u         (sc[SC_U]),
    .a         (bus.a_in[7:0]),
    .b         (bus.b_in[7:0]),
    .r         (bus.r_in[7:0]),
    .flags_in  (bus.flags_in),
    .r_out     (adj_byte),
    .flags_out (adj_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= 16'h0000;
      bus.out_size   <= 1'b0;
      bus.out_wb_en  <= 1'b0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= {bus.r_in[15:8], adj_byte};
      bus.out_size   <= bus.size;
      bus.out_wb_en  <= bus.wb_en_in;
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end

  // An explicit SC write overrides any flag merge from the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sc <= SC_RESET;
    end else if (sc_we) begin
      sc <= sc_wdata;
    end else if (accept) begin
      for (int i = 0; i < 4; i++)
        if (bus.flag_mask[i]) sc[i] <= adj_flags[i];
    end
  end

endmodule
